// File: rtl/ipa_ctx_loader.sv
// ipa_ctx_loader
// Context loader for the IPA CGRA array. On an accepted start it walks a
// context image in the GCM (header word followed by address/data record
// pairs), issues one configuration write per record, pulses execute and
// then waits for any PE to signal end-of-execution.
//
// Image layout (64-bit GCM words):
//   H : [63:48] magic tag, [15:0] record count N
//   A : configuration address in [CFG_ADDR_WIDTH-1:0], upper bits ignored
//   D : 64-bit configuration data
//
// Each GCM read is split into a request state (RD_*) and a capture state
// (WT_*) because read data arrives exactly one cycle after the request.
// This gives a 4-cycle record throughput.

module ipa_ctx_loader #(
   parameter int unsigned ADDR_MEM_WIDTH = 12,
   parameter int unsigned CFG_ADDR_WIDTH = 23,
   parameter int unsigned NB_PE          = 16,
   parameter logic [15:0] CTX_MAGIC      = 16'hC0DE
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic                      soft_clear_i,
   input  logic [ADDR_MEM_WIDTH-1:0] ctx_base_i,
   output logic                      gcm_req_o,
   output logic [ADDR_MEM_WIDTH-1:0] gcm_addr_o,
   input  logic [63:0]               gcm_rdata_i,
   output logic                      cfg_we_o,
   output logic [CFG_ADDR_WIDTH-1:0] cfg_addr_o,
   output logic [63:0]               cfg_data_o,
   output logic                      exec_en_o,
   input  logic [NB_PE-1:0]          end_exec_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_HDR,
      S_WT_HDR,
      S_RD_ADR,
      S_WT_ADR,
      S_RD_DAT,
      S_WT_DAT,
      S_EXEC,
      S_WAIT_END
   } state_t;

   state_t                    state;
   logic [ADDR_MEM_WIDTH-1:0] ptr;      // next GCM word to read; wraps naturally
   logic [15:0]               cnt;      // records still to be written
   logic [CFG_ADDR_WIDTH-1:0] addr_q;   // address word of the record in flight

   // Header fields, named for readability in the FSM
   logic [15:0] hdr_magic;
   logic [15:0] hdr_count;
   logic        any_end;

   assign hdr_magic = gcm_rdata_i[63:48];
   assign hdr_count = gcm_rdata_i[15:0];
   assign any_end   = |end_exec_i;

   // GCM request is decoded straight from the state so the read is issued in
   // the RD_* cycle itself and the data lands in the following WT_* cycle.
   // NOTE: always_comb gives every output a value on every path first, so no
   // latch can be inferred even if a state is added later.
   always_comb begin
      gcm_req_o  = 1'b0;
      gcm_addr_o = ptr;
      unique case (state)
         S_RD_HDR, S_RD_ADR, S_RD_DAT: gcm_req_o = 1'b1;
         default:                      gcm_req_o = 1'b0;
      endcase
   end

   // Main sequencer: state, datapath registers and all registered outputs.
   // NOTE: every assignment here is non-blocking so all registers update from
   // the same pre-edge values; mixing in blocking assignments would make the
   // result depend on statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= '0;
         cnt        <= '0;
         addr_q     <= '0;
         cfg_we_o   <= 1'b0;
         cfg_addr_o <= '0;
         cfg_data_o <= '0;
         exec_en_o  <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         // Single-cycle strobes fall back to zero unless a state raises them
         cfg_we_o  <= 1'b0;
         exec_en_o <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;

         if (soft_clear_i) begin
            // Abort from anywhere; silently, without done or error indication
            state  <= S_IDLE;
            busy_o <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start_i) begin
                     ptr    <= ctx_base_i;
                     busy_o <= 1'b1;
                     state  <= S_RD_HDR;
                  end
               end

               S_RD_HDR: begin
                  ptr   <= ptr + 1'b1;
                  state <= S_WT_HDR;
               end

               S_WT_HDR: begin
                  if (hdr_magic != CTX_MAGIC) begin
                     err_o  <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= S_IDLE;
                  end else if (hdr_count == 16'd0) begin
                     // Empty image: go straight to execution
                     exec_en_o <= 1'b1;
                     state     <= S_EXEC;
                  end else begin
                     cnt   <= hdr_count;
                     state <= S_RD_ADR;
                  end
               end

               S_RD_ADR: begin
                  ptr   <= ptr + 1'b1;
                  state <= S_WT_ADR;
               end

               S_WT_ADR: begin
                  addr_q <= gcm_rdata_i[CFG_ADDR_WIDTH-1:0];
                  state  <= S_RD_DAT;
               end

               S_RD_DAT: begin
                  ptr   <= ptr + 1'b1;
                  state <= S_WT_DAT;
               end

               S_WT_DAT: begin
                  // Address and data registers only change here, so they
                  // hold the last written record between strobes.
                  cfg_we_o   <= 1'b1;
                  cfg_addr_o <= addr_q;
                  cfg_data_o <= gcm_rdata_i;
                  cnt        <= cnt - 1'b1;
                  if (cnt == 16'd1) begin
                     // exec_en_o rises together with the last write strobe
                     exec_en_o <= 1'b1;
                     state     <= S_EXEC;
                  end else begin
                     state <= S_RD_ADR;
                  end
               end

               S_EXEC: begin
                  state <= S_WAIT_END;
               end

               S_WAIT_END: begin
                  if (any_end) begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= S_IDLE;
                  end
               end

               default: begin
                  busy_o <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
